// File: rtl/max_scan_ip.sv
// max_scan_ip: Avalon-MM slave that buffers a block of unsigned samples and,
// on command, scans the buffer one entry per clock to find the maximum value
// and the index of its first occurrence. Results, status and an interrupt
// are returned over the same slave port with a one-cycle registered read.
module max_scan_ip #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iChipselect_n,
    input  logic        iWrite_n,
    input  logic        iRead_n,
    input  logic [2:0]  iAddress,
    input  logic [31:0] iData,
    output logic [31:0] oData,
    output logic        oIrq
);

    localparam int CW = IDX_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_MAX    = 3'd3;
    localparam logic [2:0] A_IDX    = 3'd4;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                done_q, done_d;
    logic                empty_err_q, empty_err_d;
    logic                overflow_q, overflow_d;
    logic                irq_en_q, irq_en_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   scan_val;

    logic                wr_acc;
    logic                rd_acc;
    logic                start;
    logic                clr;
    logic                busy;
    logic                unused_data;

    assign wr_acc      = ~iChipselect_n & ~iWrite_n;
    assign rd_acc      = ~iChipselect_n & ~iRead_n;
    assign start       = wr_acc && (iAddress == A_CTRL) && iData[0];
    assign clr         = wr_acc && (iAddress == A_CTRL) && iData[1];
    assign busy        = (state_q == SCAN);
    assign scan_val    = mem_q[ptr_q[IDX_W-1:0]];
    assign unused_data = ^iData[31:DATA_W];

    assign oData = rdata_q;
    assign oIrq  = done_q & irq_en_q;

    // Register writes, scan sequencing and clear; later assignments take priority.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ptr_d       = ptr_q;
        max_d       = max_q;
        idx_d       = idx_q;
        done_d      = done_q;
        empty_err_d = empty_err_q;
        overflow_d  = overflow_q;
        irq_en_d    = irq_en_q;
        mem_we      = 1'b0;
        mem_waddr   = count_q[IDX_W-1:0];
        mem_wdata   = iData[DATA_W-1:0];

        if (wr_acc) begin
            case (iAddress)
                A_DATA: begin
                    // The buffer is frozen while a scan reads it.
                    if (!busy) begin
                        if (count_q == FULL) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            count_d = count_q + ONE;
                        end
                    end
                end
                A_CTRL: irq_en_d = iData[2];
                A_STATUS: begin
                    if (iData[1]) done_d     = 1'b0;
                    if (iData[2]) overflow_d = 1'b0;
                end
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count_q == '0) begin
                        done_d      = 1'b1;
                        empty_err_d = 1'b1;
                        max_d       = '0;
                        idx_d       = '0;
                    end else begin
                        max_d       = mem_q[0];
                        idx_d       = '0;
                        ptr_d       = ONE;
                        done_d      = 1'b0;
                        empty_err_d = 1'b0;
                        state_d     = SCAN;
                    end
                end
            end
            SCAN: begin
                if (ptr_q < count_q) begin
                    // Strict compare keeps the lowest index on ties.
                    if (scan_val > max_q) begin
                        max_d = scan_val;
                        idx_d = ptr_q[IDX_W-1:0];
                    end
                    ptr_d = ptr_q + ONE;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d     = IDLE;
            count_d     = '0;
            ptr_d       = '0;
            max_d       = '0;
            idx_d       = '0;
            done_d      = 1'b0;
            empty_err_d = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    // Read data mux; the registered value holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_acc) begin
            case (iAddress)
                A_DATA:   rdata_d = 32'(count_q);
                A_CTRL:   rdata_d = {29'd0, irq_en_q, 2'b00};
                A_STATUS: rdata_d = {16'd0, 8'(count_q), 4'd0, empty_err_q, overflow_q, done_q, busy};
                A_MAX:    rdata_d = 32'(max_q);
                A_IDX:    rdata_d = 32'(idx_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    // Control, result and read-data registers with asynchronous reset.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            ptr_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            empty_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            empty_err_q <= empty_err_d;
            overflow_q  <= overflow_d;
            irq_en_q    <= irq_en_d;
            rdata_q     <= rdata_d;
        end
    end

    // Sample buffer: plain RAM, contents survive reset and clear.
    always_ff @(posedge iClk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_max_scan_ip.sv
// Testbench for max_scan_ip: directed scenarios with literal expectations,
// then randomized bus traffic checked against a transaction-level model.
module tb_max_scan_ip;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic        wr_n;
    logic        rd_n;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] odata;
    logic        irq;

    always #5 clk = ~clk;

    max_scan_ip #(.DATA_W(16), .DEPTH(16), .IDX_W(4)) dut (
        .iClk          (clk),
        .iReset_n      (rst_n),
        .iChipselect_n (cs_n),
        .iWrite_n      (wr_n),
        .iRead_n       (rd_n),
        .iAddress      (addr),
        .iData         (wdata),
        .oData         (odata),
        .oIrq          (irq)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_buf [16];
    int          m_count;
    bit          m_irq_en, m_done, m_empty, m_ovf, m_scan;
    int          m_end;
    int          cyc = 0;
    logic [15:0] m_max, res_max;
    int          m_idx, res_idx;
    bit          rd_pend, rd_skip;
    logic [31:0] rd_exp;
    bit          busy_pre;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_count);
            3'd1:    return {29'd0, m_irq_en, 2'b00};
            3'd2:    return {16'd0, 8'(m_count), 4'd0, m_empty, m_ovf, m_done, m_scan};
            3'd3:    return {16'd0, m_max};
            3'd4:    return 32'(m_idx);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_count  = 0;
        m_irq_en = 0;
        m_done   = 0;
        m_empty  = 0;
        m_ovf    = 0;
        m_scan   = 0;
        m_max    = '0;
        m_idx    = 0;
        rd_pend  = 0;
        rd_skip  = 0;
    endtask

    // Model: applies each bus transaction at the edge it is sampled.
    // A scan is treated as one event: its result is computed at start and
    // becomes visible count cycles later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                rd_pend = !cs_n && !rd_n;
                if (rd_pend) begin
                    rd_skip = m_scan && (addr == 3'd3 || addr == 3'd4);
                    rd_exp  = model_read(addr);
                end
                busy_pre = m_scan;
                if (!cs_n && !wr_n && addr == 3'd0 && !busy_pre) begin
                    if (m_count == 16) m_ovf = 1;
                    else begin
                        m_buf[m_count] = wdata[15:0];
                        m_count++;
                    end
                end
                if (!cs_n && !wr_n && addr == 3'd2) begin
                    if (wdata[1]) m_done = 0;
                    if (wdata[2]) m_ovf  = 0;
                end
                if (m_scan && cyc == m_end) begin
                    m_scan = 0;
                    m_done = 1;
                    m_max  = res_max;
                    m_idx  = res_idx;
                end
                if (!cs_n && !wr_n && addr == 3'd1) begin
                    m_irq_en = wdata[2];
                    if (wdata[1]) begin
                        m_count = 0;
                        m_scan  = 0;
                        m_done  = 0;
                        m_empty = 0;
                        m_ovf   = 0;
                        m_max   = '0;
                        m_idx   = 0;
                    end else if (wdata[0] && !busy_pre) begin
                        if (m_count == 0) begin
                            m_done  = 1;
                            m_empty = 1;
                            m_max   = '0;
                            m_idx   = 0;
                        end else begin
                            res_max = m_buf[0];
                            res_idx = 0;
                            for (int i = 1; i < m_count; i++) begin
                                if (m_buf[i] > res_max) begin
                                    res_max = m_buf[i];
                                    res_idx = i;
                                end
                            end
                            m_scan  = 1;
                            m_end   = cyc + m_count;
                            m_done  = 0;
                            m_empty = 0;
                        end
                    end
                end
            end
        end
    end

    // Compare: interrupt every cycle, read data after every read.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
                if (rd_pend && !rd_skip) chk("rdata", odata, rd_exp);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs_n  = 1'b0;
        wr_n  = 1'b0;
        addr  = a;
        wdata = d;
        @(negedge clk);
        cs_n  = 1'b1;
        wr_n  = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        cs_n = 1'b0;
        rd_n = 1'b0;
        addr = a;
        @(negedge clk);
        v    = odata;
        cs_n = 1'b1;
        rd_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] v;
    int          r;
    logic [15:0] val;

    initial begin
        rst_n = 1'b0;
        cs_n  = 1'b1;
        wr_n  = 1'b1;
        rd_n  = 1'b1;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        rd(3'd0, v); chk("rst_count", v, 32'd0);
        rd(3'd2, v); chk("rst_status", v, 32'd0);
        rd(3'd3, v); chk("rst_max", v, 32'd0);
        rd(3'd4, v); chk("rst_idx", v, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // Basic scan with a tie: first occurrence wins
        wr(3'd0, 32'd3); wr(3'd0, 32'd9); wr(3'd0, 32'd2); wr(3'd0, 32'd9); wr(3'd0, 32'd7);
        wr(3'd1, 32'h1);
        rd(3'd2, v); chk("busy_first", v, 32'h0501);
        rd(3'd2, v); rd(3'd2, v); rd(3'd2, v);
        rd(3'd2, v); chk("busy_last", v, 32'h0501);
        rd(3'd2, v); chk("done_t5", v, 32'h0502);
        rd(3'd3, v); chk("max_tie", v, 32'd9);
        rd(3'd4, v); chk("idx_tie", v, 32'd1);
        rd(3'd0, v); chk("count5", v, 32'd5);
        chk("mdl_idx", 32'(m_idx), 32'd1);

        // Single entry with interrupt, upper data bits ignored
        wr(3'd1, 32'h2);
        wr(3'd1, 32'h4);
        wr(3'd0, 32'hABCD_FFFF);
        wr(3'd1, 32'h5);
        idle(1);
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd(3'd3, v); chk("max_ffff", v, 32'h0000_FFFF);
        rd(3'd4, v); chk("idx_0", v, 32'd0);
        wr(3'd2, 32'h2);
        chk("irq_clr", {31'd0, irq}, 32'd0);

        // Empty start, overflow, full-depth scan
        wr(3'd1, 32'h2);
        wr(3'd1, 32'h1);
        rd(3'd2, v); chk("empty_err", v, 32'h000A);
        rd(3'd3, v); chk("empty_max", v, 32'd0);
        for (int i = 0; i < 17; i++) wr(3'd0, 32'((i * 7) % 16 + 100));
        rd(3'd2, v); chk("ovf_status", v, 32'h100E);
        rd(3'd0, v); chk("count16", v, 32'd16);
        wr(3'd1, 32'h1);
        idle(17);
        rd(3'd2, v); chk("full_done", v, 32'h1006);
        rd(3'd3, v); chk("full_max", v, 32'd115);
        rd(3'd4, v); chk("full_idx", v, 32'd9);
        chk("mdl_max", {16'd0, m_max}, 32'd115);

        // Interference during a scan is ignored; clear aborts it
        wr(3'd1, 32'h1);
        idle(3);
        wr(3'd0, 32'd999);
        wr(3'd1, 32'h1);
        idle(20);
        rd(3'd3, v); chk("intf_max", v, 32'd115);
        rd(3'd4, v); chk("intf_idx", v, 32'd9);
        rd(3'd0, v); chk("intf_count", v, 32'd16);
        wr(3'd1, 32'h1);
        idle(4);
        wr(3'd1, 32'h2);
        rd(3'd2, v); chk("clr_status", v, 32'd0);
        rd(3'd0, v); chk("clr_count", v, 32'd0);

        // Asynchronous reset mid-scan, then a fresh block
        wr(3'd0, 32'd10); wr(3'd0, 32'd20); wr(3'd0, 32'd30); wr(3'd0, 32'd40); wr(3'd0, 32'd50);
        wr(3'd1, 32'h1);
        idle(2);
        rd(3'd0, v); chk("pre_rst_count", v, 32'd5);
        #2 rst_n = 1'b0;
        #1 chk("arst_odata", odata, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(3'd2, v); chk("post_rst_status", v, 32'd0);
        wr(3'd0, 32'd4); wr(3'd0, 32'd1); wr(3'd0, 32'd8); wr(3'd0, 32'd8);
        wr(3'd1, 32'h1);
        idle(6);
        rd(3'd3, v); chk("post_rst_max", v, 32'd8);
        rd(3'd4, v); chk("post_rst_idx", v, 32'd2);

        // Randomized traffic checked by the model
        for (int it = 0; it < 700; it++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                val = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 65535));
                wr(3'd0, {16'($urandom), val});
            end else if (r < 50) begin
                wr(3'd1, {29'd0, 1'($urandom_range(0, 1)), 2'b01});
            end else if (r < 53) begin
                wr(3'd1, {29'd0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))});
            end else if (r < 58) begin
                wr(3'd2, $urandom);
            end else if (r < 60) begin
                wr(3'($urandom_range(5, 7)), $urandom);
            end else if (r < 85) begin
                rd(3'($urandom_range(0, 7)), v);
            end else begin
                idle($urandom_range(1, 8));
            end
        end
        idle(20);
        rd(3'd2, v);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
